// File: rtl/input_mems_pingpong.sv
// Double-buffered A/B matrix loader for the matrix-multiply datapath.
// Streams sets over AXI-Stream into ping-pong banks while the compute unit reads the head set.
module input_mems_pingpong #(
    parameter int INW  = 12,
    parameter int M    = 7,
    parameter int N    = 9,
    parameter int MAXK = 8,
    localparam int K_BITS      = $clog2(MAXK + 1),
    localparam int A_ADDR_BITS = $clog2(M * MAXK),
    localparam int B_ADDR_BITS = $clog2(MAXK * N)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [INW-1:0]         AXIS_TDATA,
    input  logic                   AXIS_TVALID,
    input  logic [K_BITS:0]        AXIS_TUSER,
    output logic                   AXIS_TREADY,
    output logic                   matrices_loaded,
    input  logic                   compute_finished,
    output logic [K_BITS-1:0]      K,
    input  logic [A_ADDR_BITS-1:0] A_read_addr,
    output logic [INW-1:0]         A_data,
    input  logic [B_ADDR_BITS-1:0] B_read_addr,
    output logic [INW-1:0]         B_data,
    output logic                   err_bad_k
);
    localparam int WR_BITS = (A_ADDR_BITS > B_ADDR_BITS) ? A_ADDR_BITS : B_ADDR_BITS;

    typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B} state_t;

    typedef struct packed {
        logic              a_bank;
        logic              b_bank;
        logic [K_BITS-1:0] k;
    } desc_t;

    state_t            state, state_next;
    logic [WR_BITS-1:0] wr_addr, wr_addr_next, wr_idx;
    logic              cur_new_a, cur_new_a_next;
    logic [K_BITS-1:0] cur_k, cur_k_next;
    logic              b_wr, last_a;
    desc_t             desc_q [2];
    desc_t             head;
    logic              rd_ptr, wr_ptr;
    logic [1:0]        count, count_next;
    logic [K_BITS-1:0] k_last;
    logic              a_sel, b_sel;

    logic              user_new_a, user_k_bad;
    logic [K_BITS-1:0] user_k;
    logic              eff_new_a;
    logic [K_BITS-1:0] eff_k;
    int                a_last, b_last;
    logic              beat, push, pop, set_err;
    logic [1:0]        we_a, we_b;
    logic [A_ADDR_BITS-1:0] a_wr_addr;
    logic [B_ADDR_BITS-1:0] b_wr_addr;

    assign user_new_a = AXIS_TUSER[0];
    assign user_k     = AXIS_TUSER[K_BITS:1];
    assign user_k_bad = (user_k == '0) || (int'(user_k) > MAXK);

    // In IDLE the set header is still on TUSER; afterwards it lives in cur_*.
    assign eff_new_a = (state == IDLE) ? user_new_a : cur_new_a;
    assign eff_k     = (state == IDLE) ? user_k : cur_k;
    assign a_last    = M * int'(eff_k) - 1;
    assign b_last    = int'(eff_k) * N - 1;

    assign AXIS_TREADY = !reset && ((state != IDLE) || (count < 2'd2));
    assign beat        = AXIS_TVALID && AXIS_TREADY;
    assign pop         = compute_finished && matrices_loaded;
    assign head        = desc_q[rd_ptr];
    assign count_next  = count + {1'b0, push} - {1'b0, pop};
    assign K           = matrices_loaded ? head.k : k_last;

    always_comb begin
        state_next     = state;
        wr_addr_next   = wr_addr;
        cur_new_a_next = cur_new_a;
        cur_k_next     = cur_k;
        wr_idx         = wr_addr;
        push           = 1'b0;
        set_err        = 1'b0;
        we_a           = '0;
        we_b           = '0;
        case (state)
            IDLE: begin
                wr_idx = '0;
                if (beat) begin
                    if (user_k_bad) begin
                        set_err = 1'b1;
                    end else begin
                        cur_new_a_next = user_new_a;
                        cur_k_next     = user_k;
                        if (user_new_a) begin
                            we_a[~last_a] = 1'b1;
                            if (a_last == 0) begin
                                state_next   = LOAD_B;
                                wr_addr_next = '0;
                            end else begin
                                state_next   = LOAD_A;
                                wr_addr_next = WR_BITS'(1);
                            end
                        end else begin
                            we_b[b_wr] = 1'b1;
                            if (b_last == 0) begin
                                push = 1'b1;
                            end else begin
                                state_next   = LOAD_B;
                                wr_addr_next = WR_BITS'(1);
                            end
                        end
                    end
                end
            end
            LOAD_A: begin
                if (beat) begin
                    we_a[~last_a] = 1'b1;
                    if (int'(wr_addr) == a_last) begin
                        state_next   = LOAD_B;
                        wr_addr_next = '0;
                    end else begin
                        wr_addr_next = wr_addr + 1'b1;
                    end
                end
            end
            LOAD_B: begin
                if (beat) begin
                    we_b[b_wr] = 1'b1;
                    if (int'(wr_addr) == b_last) begin
                        push         = 1'b1;
                        state_next   = IDLE;
                        wr_addr_next = '0;
                    end else begin
                        wr_addr_next = wr_addr + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            wr_addr         <= '0;
            cur_new_a       <= 1'b0;
            cur_k           <= '0;
            b_wr            <= 1'b0;
            last_a          <= 1'b1;
            err_bad_k       <= 1'b0;
            rd_ptr          <= 1'b0;
            wr_ptr          <= 1'b0;
            count           <= '0;
            matrices_loaded <= 1'b0;
            k_last          <= '0;
            a_sel           <= 1'b0;
            b_sel           <= 1'b0;
            desc_q[0]       <= '0;
            desc_q[1]       <= '0;
        end else begin
            state     <= state_next;
            wr_addr   <= wr_addr_next;
            cur_new_a <= cur_new_a_next;
            cur_k     <= cur_k_next;
            if (set_err) err_bad_k <= 1'b1;
            // A reuse points the descriptor at the most recently loaded A bank.
            if (push) begin
                desc_q[wr_ptr] <= {last_a ^ eff_new_a, b_wr, eff_k};
                wr_ptr         <= ~wr_ptr;
                b_wr           <= ~b_wr;
                if (eff_new_a) last_a <= ~last_a;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count           <= count_next;
            matrices_loaded <= (count_next != 2'd0);
            k_last          <= K;
            a_sel           <= head.a_bank;
            b_sel           <= head.b_bank;
        end
    end

    assign a_wr_addr = wr_idx[A_ADDR_BITS-1:0];
    assign b_wr_addr = wr_idx[B_ADDR_BITS-1:0];

    // Single-port banks: a write cycle holds the output register.
    for (genvar g = 0; g < 2; g++) begin : g_bank
        logic [INW-1:0] a_mem [M*MAXK];
        logic [INW-1:0] b_mem [MAXK*N];
        logic [INW-1:0] a_q, b_q;

        always_ff @(posedge clk) begin
            if (we_a[g]) a_mem[a_wr_addr] <= AXIS_TDATA;
            if (we_b[g]) b_mem[b_wr_addr] <= AXIS_TDATA;
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                a_q <= '0;
                b_q <= '0;
            end else begin
                if (!we_a[g]) a_q <= a_mem[A_read_addr];
                if (!we_b[g]) b_q <= b_mem[B_read_addr];
            end
        end
    end

    assign A_data = a_sel ? g_bank[1].a_q : g_bank[0].a_q;
    assign B_data = b_sel ? g_bank[1].b_q : g_bank[0].b_q;

endmodule

// File: tb/tb_input_mems_pingpong.sv
// Randomized bench for input_mems_pingpong, checked against a set-level model:
// a two-entry queue of whole matrices plus the last A matrix loaded.
module tb_input_mems_pingpong;
    localparam int INW         = 12;
    localparam int M           = 7;
    localparam int N           = 9;
    localparam int MAXK        = 8;
    localparam int K_BITS      = $clog2(MAXK + 1);
    localparam int A_ADDR_BITS = $clog2(M * MAXK);
    localparam int B_ADDR_BITS = $clog2(MAXK * N);
    localparam int A_WORDS     = M * MAXK;
    localparam int B_WORDS     = MAXK * N;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [INW-1:0]         axis_tdata;
    logic                   axis_tvalid;
    logic [K_BITS:0]        axis_tuser;
    logic                   axis_tready;
    logic                   matrices_loaded;
    logic                   compute_finished;
    logic [K_BITS-1:0]      K;
    logic [A_ADDR_BITS-1:0] A_read_addr;
    logic [INW-1:0]         A_data;
    logic [B_ADDR_BITS-1:0] B_read_addr;
    logic [INW-1:0]         B_data;
    logic                   err_bad_k;

    input_mems_pingpong #(.INW(INW), .M(M), .N(N), .MAXK(MAXK)) dut (
        .clk(clk), .reset(reset),
        .AXIS_TDATA(axis_tdata), .AXIS_TVALID(axis_tvalid), .AXIS_TUSER(axis_tuser),
        .AXIS_TREADY(axis_tready), .matrices_loaded(matrices_loaded),
        .compute_finished(compute_finished), .K(K),
        .A_read_addr(A_read_addr), .A_data(A_data),
        .B_read_addr(B_read_addr), .B_data(B_data), .err_bad_k(err_bad_k)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [INW-1:0] set_a [2][A_WORDS];
    logic [INW-1:0] set_b [2][B_WORDS];
    int             set_k [2];
    int             q_head, q_count, shown_k, last_a_k;
    bit             exp_err;
    logic [INW-1:0] last_a_vals [A_WORDS];
    logic [INW-1:0] stage_a [A_WORDS];
    logic [INW-1:0] stage_b [B_WORDS];
    int             n_checks, n_fail;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        q_head   = 0;
        q_count  = 0;
        shown_k  = 0;
        last_a_k = 0;
        exp_err  = 1'b0;
    endfunction

    function automatic void model_pop();
        if (q_count > 0) begin
            if (q_count == 1) shown_k = set_k[q_head];
            q_head  = q_head ^ 1;
            q_count = q_count - 1;
        end
    endfunction

    function automatic void model_push(input bit new_a, input int k);
        int slot;
        slot = (q_head + q_count) % 2;
        if (new_a) begin
            for (int i = 0; i < A_WORDS; i++) last_a_vals[i] = stage_a[i];
            last_a_k = k;
        end
        for (int i = 0; i < A_WORDS; i++) set_a[slot][i] = last_a_vals[i];
        for (int i = 0; i < B_WORDS; i++) set_b[slot][i] = stage_b[i];
        set_k[slot] = k;
        q_count = q_count + 1;
    endfunction

    task automatic check_state(input string tag);
        checkOutput({tag, "_loaded"}, 32'(matrices_loaded), 32'(q_count > 0));
        checkOutput({tag, "_K"}, 32'(K), (q_count > 0) ? set_k[q_head] : shown_k);
        checkOutput({tag, "_err"}, 32'(err_bad_k), 32'(exp_err));
    endtask

    // One beat, called #1 after a rising edge; optional compute_finished in its first cycle.
    task automatic send_beat(input logic [INW-1:0] d, input logic [K_BITS:0] user, input bit pulse);
        bit ready;
        bit ok;
        ok = 1'b0;
        if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
        end
        axis_tdata       = d;
        axis_tuser       = user;
        axis_tvalid      = 1'b1;
        compute_finished = pulse;
        for (int t = 0; t < 40 && !ok; t++) begin
            @(negedge clk);
            ready = axis_tready;
            if (t == 0 && pulse) model_pop();
            @(posedge clk);
            #1;
            compute_finished = 1'b0;
            if (ready) ok = 1'b1;
        end
        axis_tvalid = 1'b0;
        if (!ok) checkOutput("tready_timeout", 32'd0, 32'd1);
    endtask

    // kind 0: A=idx, B=100+idx; kind 1: A=-idx, B=200+idx; kind 2: random.
    task automatic applyStimulus(input bit new_a, input int k, input int kind,
                                 input bit pop_last, input int abort_at);
        int na;
        int nb;
        logic [INW-1:0] d;
        na = new_a ? M * k : 0;
        nb = k * N;
        for (int i = 0; i < na; i++)
            stage_a[i] = (kind == 0) ? INW'(i) : (kind == 1) ? INW'(-i) : INW'($urandom);
        for (int i = 0; i < nb; i++)
            stage_b[i] = (kind == 0) ? INW'(100 + i) : (kind == 1) ? INW'(200 + i) : INW'($urandom);
        for (int i = 0; i < na + nb; i++) begin
            if (i < na) d = stage_a[i];
            else        d = stage_b[i - na];
            if (abort_at >= 0 && i == abort_at) begin
                reset = 1'b1;
                repeat (2) begin
                    @(posedge clk);
                    #1;
                end
                reset = 1'b0;
                model_reset();
                return;
            end
            if (i == na + nb - 1)
                checkOutput("loaded_before_last", 32'(matrices_loaded), 32'(q_count > 0));
            else if (i % 8 == 0)
                check_state("stream");
            send_beat(d, {K_BITS'(k), new_a}, pop_last && (i == na + nb - 1));
        end
        model_push(new_a, k);
    endtask

    task automatic read_check(input int a_addr, input int b_addr);
        A_read_addr = A_ADDR_BITS'(a_addr);
        B_read_addr = B_ADDR_BITS'(b_addr);
        @(posedge clk);
        #1;
        checkOutput($sformatf("A_data[%0d]", a_addr), 32'(A_data), 32'(set_a[q_head][a_addr]));
        checkOutput($sformatf("B_data[%0d]", b_addr), 32'(B_data), 32'(set_b[q_head][b_addr]));
    endtask

    task automatic random_reads(input int count);
        int k;
        for (int r = 0; r < count; r++) begin
            k = set_k[q_head];
            read_check($urandom_range(0, M * k - 1), $urandom_range(0, k * N - 1));
        end
    endtask

    task automatic do_pop();
        compute_finished = 1'b1;
        model_pop();
        @(posedge clk);
        #1;
        compute_finished = 1'b0;
    endtask

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit na;
        int k;
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1;
        axis_tvalid = 1'b0;
        axis_tdata = '0;
        axis_tuser = '0;
        compute_finished = 1'b0;
        A_read_addr = '0;
        B_read_addr = '0;
        model_reset();
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checkOutput("reset_tready", 32'(axis_tready), 32'd0);
        checkOutput("reset_A_data", 32'(A_data), 32'd0);
        checkOutput("reset_B_data", 32'(B_data), 32'd0);
        check_state("reset");
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("idle_tready", 32'(axis_tready), 32'd1);

        $display("[TB] single full-size set");
        applyStimulus(1'b1, 8, 0, 1'b0, -1);
        check_state("set1");
        read_check(10, 71);
        checkOutput("plan_A10", 32'(A_data), 32'd10);
        checkOutput("plan_B71", 32'(B_data), 32'd171);

        $display("[TB] overlapping second set");
        applyStimulus(1'b1, 3, 1, 1'b0, -1);
        check_state("set2");
        axis_tvalid = 1'b1;
        axis_tuser  = {K_BITS'(3), 1'b1};
        @(negedge clk);
        checkOutput("full_tready", 32'(axis_tready), 32'd0);
        @(posedge clk);
        #1;
        axis_tvalid = 1'b0;
        read_check(10, 71);
        do_pop();
        check_state("pop1");
        read_check(4, 5);
        checkOutput("plan_Aneg4", 32'(A_data), 32'h0000_0ffc);
        do_pop();
        check_state("empty");
        do_pop();
        check_state("pop_ignored");

        $display("[TB] A reuse");
        applyStimulus(1'b1, 4, 2, 1'b0, -1);
        applyStimulus(1'b0, 4, 2, 1'b0, -1);
        check_state("reuse_full");
        do_pop();
        check_state("reuse_head");
        random_reads(4);

        $display("[TB] push and pop in the same cycle");
        applyStimulus(1'b1, 5, 2, 1'b1, -1);
        checkOutput("pp_tready", 32'(axis_tready), 32'd1);
        check_state("pushpop");
        random_reads(3);

        $display("[TB] bad K");
        do_pop();
        send_beat(12'h05a, {K_BITS'(0), 1'b1}, 1'b0);
        exp_err = 1'b1;
        check_state("badk0");
        send_beat(12'h05b, {K_BITS'(9), 1'b1}, 1'b0);
        check_state("badk9");
        applyStimulus(1'b1, 2, 2, 1'b0, -1);
        check_state("after_bad");
        random_reads(3);

        $display("[TB] reset during a load");
        do_pop();
        applyStimulus(1'b1, 5, 2, 1'b0, 20);
        check_state("after_reset");
        applyStimulus(1'b1, 6, 2, 1'b0, -1);
        check_state("fresh");
        random_reads(3);

        $display("[TB] random traffic");
        for (int it = 0; it < 10; it++) begin
            if (q_count < 2 && $urandom_range(0, 2) != 0) begin
                na = (last_a_k == 0) || ($urandom_range(0, 1) == 1);
                k  = na ? int'($urandom_range(1, MAXK)) : last_a_k;
                applyStimulus(na, k, 2, 1'($urandom_range(0, 1)), -1);
                check_state("rnd_set");
            end
            if (q_count > 0) random_reads(2);
            if ($urandom_range(0, 1) == 1) begin
                do_pop();
                check_state("rnd_pop");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/input_mems_pingpong.md
Name: input_mems_pingpong

Overview:
- Parametrised successor to the single-buffer matrix input loader, for the same matrix-multiply datapath.
- Accepts A (M x K) and B (K x N) matrices over an AXI-Stream slave.
- Double-buffers both matrices, so the next set loads while the compute unit reads the current one.
- Supports A reuse (new_A=0), so only B is streamed. Up to two complete sets are queued.

Parameters:
INW, 12, element width in bits (signed)
M, 7, rows of A
N, 9, columns of B
MAXK, 8, maximum shared dimension K
K_BITS, $clog2(MAXK+1), localparam, width of K
A_ADDR_BITS, $clog2(M*MAXK), localparam, A read address width
B_ADDR_BITS, $clog2(MAXK*N), localparam, B read address width

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
AXIS_TDATA  in  INW  stream element
AXIS_TVALID  in  1  stream valid
AXIS_TUSER  in  K_BITS+1  bit0 = new_A; bits[K_BITS:1] = K; sampled only on the first beat of a set
AXIS_TREADY  out  1  stream ready
matrices_loaded  out  1  head set is complete and readable
compute_finished  in  1  one-cycle pulse; releases the head set
K  out  K_BITS  K of the head set
A_read_addr  in  A_ADDR_BITS  A element address, row-major i*K+k
A_data  out  INW  A element from the head set's A bank
B_read_addr  in  B_ADDR_BITS  B element address, row-major k*N+j
B_data  out  INW  B element from the head set's B bank
err_bad_k  out  1  sticky flag: a set with K=0 or K>MAXK was received

Behaviour:
- Storage: two A banks (M*MAXK words each) and two B banks (MAXK*N words each). Each bank is a single-port synchronous RAM with a registered output.
- Beat transfer: a beat transfers when AXIS_TVALID & AXIS_TREADY.
- Set stream order: if new_A=1, M*K A elements in stream order, then K*N B elements. If new_A=0, K*N B elements only. Elements are written to addresses 0, 1, 2, ...
- Loader FSM states: IDLE, LOAD_A, LOAD_B.
- IDLE: AXIS_TREADY = (count<2). On the first transferred beat:
  - latch new_A and K from TUSER;
  - write the beat as element 0;
  - if new_A=1 go to LOAD_A (or to LOAD_B when M*K=1); if new_A=0 go to LOAD_B.
- LOAD_A / LOAD_B: AXIS_TREADY=1. The write address counter wraps to 0 on the phase change. Transfer of the last B beat (index K*N-1) pushes the set descriptor and returns to IDLE.
- Set descriptor: {a_bank, b_bank, K}.
- B bank allocation: b_wr toggles on every push; reset value 0.
- A bank allocation:
  - new_A=1 writes A bank ~last_a; on push, last_a <= ~last_a.
  - new_A=0 sets the descriptor's a_bank to last_a. A contents are whatever was last loaded; undefined if no A has been loaded since reset.
  - last_a resets to 1, so the first A load goes to bank 0.
- Bank safety: when count==1 the head set is always the most recent set, so writing banks ~last_a and b_wr never corrupts the head. The upstream must send the same K when reusing A; a mismatch is not checked.
- Bad K: if the first beat carries K=0 or K>MAXK:
  - the beat is accepted and discarded;
  - no descriptor is pushed and the FSM stays in IDLE;
  - err_bad_k <= 1 and stays set until reset.
- Queue: 2 entries, count in 0..2.
  - matrices_loaded = (count>=1), registered, so it asserts the cycle after the last B beat.
  - K shows the head descriptor's K whenever matrices_loaded=1 and holds its last value otherwise; reset value 0.
- Release: compute_finished while matrices_loaded=1 pops the head. compute_finished while matrices_loaded=0 is ignored.
- Push and pop in the same cycle: count is unchanged. With count=1, the new set becomes head on the next cycle and matrices_loaded stays 1.
- Read latency: 1 cycle. A_data/B_data reflect the address presented in the previous cycle, using the head banks of that cycle.
- Reset values: AXIS_TREADY=0 during reset; matrices_loaded=0; K=0; A_data=0; B_data=0; err_bad_k=0; count=0; FSM=IDLE.
- Reset mid-load: the partial set is discarded. RAM contents are not cleared.

Test Plan:
- Single set, M=7, N=9, K=8, new_A=1, values A=idx, B=100+idx. Response: 56+72 beats accepted; matrices_loaded rises 1 cycle after the last beat; K=8; A_read_addr=10 gives A_data=10 next cycle; B_read_addr=71 gives B_data=171.
- Overlap: after set 1, stream set 2 (K=3, new_A=1, A=-idx) without pulsing compute_finished. Response: TREADY=0 in IDLE after set 2 completes (count=2); head still returns set 1 data. A compute_finished pulse then gives K=3 and A_data(addr 4)=-4.
- Reuse: set 1 loaded with new_A=1 and K=4, then set 2 with new_A=0, K=4 (36 B beats only). Response: after popping set 1, A_data equals set 1's A and B_data equals set 2's B.
- Simultaneous push/pop: pulse compute_finished in the same cycle as set 2's last beat. Response: count stays 1, matrices_loaded never drops, head switches to set 2 the next cycle.
- Bad K and reset: first beat with K=0, then K=9. Response: err_bad_k=1 and no push; the next valid set loads normally. Assert reset at beat 20 of a set: the following fresh set loads correctly with matrices_loaded=0 until it completes.
